// File: rtl/fabric_pe_const_seq.sv
// -----------------------------------------------------------------------------
// fabric_pe_const_seq
//
// Triggered constant / arithmetic-sequence generator PE for the fabric.
// Each accepted trigger token produces either one constant (mode 0) or the
// sequence start, start+step, ... of COUNT values (mode 1). Elements leave
// through a single registered valid/ready slot. The slot marks the final
// element of each trigger with out_last.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   trigger token valid
//   in_ready   trigger accepted when in_valid && in_ready
//   in_data    trigger payload (ignored, never forwarded)
//   out_valid  output element valid
//   out_ready  downstream ready
//   out_data   {tag, value}; value only when TAG_WIDTH == 0
//   out_last   element is the final one for its trigger
//   busy       a multi-element sequence is still being generated
//   cfg_data   {tag, mode, count, step, start}, start in the LSBs
// -----------------------------------------------------------------------------
module fabric_pe_const_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
    localparam int SAFE_PW       = (PAYLOAD_WIDTH > 1) ? PAYLOAD_WIDTH : 1,
    localparam int CONFIG_WIDTH  = 1 + 2*DATA_WIDTH + CNT_WIDTH + TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SAFE_PW-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SAFE_PW-1:0]      out_data,
    output logic                    out_last,
    output logic                    busy,
    input  logic [CONFIG_WIDTH-1:0] cfg_data
);

    // Tag registers keep at least one bit so the untagged build stays legal.
    localparam int SAFE_TW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "fabric_pe_const_seq: DATA_WIDTH must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $fatal(1, "fabric_pe_const_seq: CNT_WIDTH must be >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Configuration field decode
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] cfg_start;
    logic [DATA_WIDTH-1:0] cfg_step;
    logic [CNT_WIDTH-1:0]  cfg_count;
    logic                  cfg_mode;
    logic [SAFE_TW-1:0]    cfg_tag;

    assign cfg_start = cfg_data[DATA_WIDTH-1:0];
    assign cfg_step  = cfg_data[DATA_WIDTH +: DATA_WIDTH];
    assign cfg_count = cfg_data[2*DATA_WIDTH +: CNT_WIDTH];
    assign cfg_mode  = cfg_data[2*DATA_WIDTH + CNT_WIDTH];

    if (TAG_WIDTH > 0) begin : g_cfg_tag
        assign cfg_tag = cfg_data[CONFIG_WIDTH-1 -: TAG_WIDTH];
    end else begin : g_cfg_no_tag
        assign cfg_tag = '0;
    end

    // -------------------------------------------------------------------------
    // State and sequence registers
    // -------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
    logic [DATA_WIDTH-1:0] step_q,  step_d;
    logic [CNT_WIDTH-1:0]  rem_q,   rem_d;
    logic [SAFE_TW-1:0]    tag_q,   tag_d;

    // Output-slot load request produced by the next-state logic.
    logic                  load;
    logic [DATA_WIDTH-1:0] load_value;
    logic [SAFE_TW-1:0]    load_tag;
    logic                  load_last;
    logic [SAFE_PW-1:0]    load_payload;

    logic slot_free;
    logic accept;

    // The slot can take a new element when it is empty or draining this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == S_EMIT);

    // -------------------------------------------------------------------------
    // Next-state / slot-load logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        acc_d      = acc_q;
        step_d     = step_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        load       = 1'b0;
        load_value = '0;
        load_tag   = tag_q;
        load_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Configuration is captured here; later cfg_data changes
                    // cannot reach a sequence already in flight.
                    step_d   = cfg_step;
                    tag_d    = cfg_tag;
                    load_tag = cfg_tag;
                    if (!cfg_mode) begin
                        load       = 1'b1;
                        load_value = cfg_start;
                        load_last  = 1'b1;
                    end else if (cfg_count == '0) begin
                        // Empty sequence: the token is consumed, nothing emitted.
                        load = 1'b0;
                    end else if (cfg_count == CNT_WIDTH'(1)) begin
                        load       = 1'b1;
                        load_value = cfg_start;
                        load_last  = 1'b1;
                    end else begin
                        // First element goes straight to the slot; the
                        // accumulator already holds the second one.
                        load       = 1'b1;
                        load_value = cfg_start;
                        load_last  = 1'b0;
                        acc_d      = cfg_start + cfg_step;
                        rem_d      = cfg_count - CNT_WIDTH'(1);
                        state_d    = S_EMIT;
                    end
                end
            end

            S_EMIT: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_value = acc_q;
                    load_last  = (rem_q == CNT_WIDTH'(1));
                    acc_d      = acc_q + step_q;
                    rem_d      = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    if (TAG_WIDTH > 0) begin : g_pack_tag
        assign load_payload = {load_tag, load_value};
    end else begin : g_pack_no_tag
        assign load_payload = load_value;
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the datapath ones, is reset so a
        // sequence abandoned by reset leaves no stale value behind.
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
        end
    end

    // Output slot: loads only when free, otherwise holds data and last stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= load_last;
            out_data  <= load_payload;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The trigger payload is intentionally ignored; the tag mux output is only
    // consumed by the tagged build.
    logic unused_sink;
    assign unused_sink = ^{in_data, load_tag};

endmodule
